// File: rtl/alu_operand_entry.sv
// Operand entry sequencer: loads A, B and the ALU opcode from one switch bank,
// one debounced ENTER press per step, with a debounced CLEAR back to LOAD_A.
module alu_operand_entry #(
   parameter int n               = 3,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   sw,
   input  logic         btn_enter,
   input  logic         btn_clear,
   output logic [n-1:0] a,
   output logic [n-1:0] b,
   output logic [3:0]   ALUControl,
   output logic         valid,
   output logic [1:0]   stage
);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      SHOW    = 2'd3
   } state_t;

   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   logic [1:0]   ent_sync_q, clr_sync_q;
   logic         ent_lvl_q, ent_lvl_d, clr_lvl_q, clr_lvl_d;
   logic [7:0]   ent_cnt_q, ent_cnt_d, clr_cnt_q, clr_cnt_d;
   logic         ev_enter_q, ev_enter_d, ev_clear_q, ev_clear_d;
   state_t       state_q;
   logic [n-1:0] a_q, b_q;
   logic [3:0]   op_q;
   logic         valid_q;

   logic s_enter, s_clear;
   assign s_enter = ent_sync_q[1];
   assign s_clear = clr_sync_q[1];

   // The press pulse is registered alongside the level change, so the FSM
   // acts on the edge after the debounced level rises.
   always_comb begin
      ent_lvl_d  = ent_lvl_q;
      ent_cnt_d  = ent_cnt_q;
      ev_enter_d = 1'b0;
      if (s_enter == ent_lvl_q) begin
         ent_cnt_d = '0;
      end else if (ent_cnt_q == CNT_MAX) begin
         ent_lvl_d  = s_enter;
         ent_cnt_d  = '0;
         ev_enter_d = s_enter;
      end else begin
         ent_cnt_d = ent_cnt_q + 8'd1;
      end

      clr_lvl_d  = clr_lvl_q;
      clr_cnt_d  = clr_cnt_q;
      ev_clear_d = 1'b0;
      if (s_clear == clr_lvl_q) begin
         clr_cnt_d = '0;
      end else if (clr_cnt_q == CNT_MAX) begin
         clr_lvl_d  = s_clear;
         clr_cnt_d  = '0;
         ev_clear_d = s_clear;
      end else begin
         clr_cnt_d = clr_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_sync_q <= '0;
         clr_sync_q <= '0;
         ent_lvl_q  <= 1'b0;
         clr_lvl_q  <= 1'b0;
         ent_cnt_q  <= '0;
         clr_cnt_q  <= '0;
         ev_enter_q <= 1'b0;
         ev_clear_q <= 1'b0;
      end else begin
         ent_sync_q <= {ent_sync_q[0], btn_enter};
         clr_sync_q <= {clr_sync_q[0], btn_clear};
         ent_lvl_q  <= ent_lvl_d;
         clr_lvl_q  <= clr_lvl_d;
         ent_cnt_q  <= ent_cnt_d;
         clr_cnt_q  <= clr_cnt_d;
         ev_enter_q <= ev_enter_d;
         ev_clear_q <= ev_clear_d;
      end
   end

   // Clear outranks enter when both events land in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || ev_clear_q) begin
         state_q <= LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else if (ev_enter_q) begin
         case (state_q)
            LOAD_A: begin
               a_q     <= sw[n-1:0];
               state_q <= LOAD_B;
            end
            LOAD_B: begin
               b_q     <= sw[n-1:0];
               state_q <= LOAD_OP;
            end
            LOAD_OP: begin
               op_q    <= sw;
               valid_q <= 1'b1;
               state_q <= SHOW;
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= LOAD_A;
            end
         endcase
      end
   end

   assign a          = a_q;
   assign b          = b_q;
   assign ALUControl = op_q;
   assign valid      = valid_q;
   assign stage      = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry: directed sequences plus random button activity,
// every cycle checked against a sliding-window reference model.
module tb_alu_operand_entry;

   localparam int N  = 3;
   localparam int DC = 4;
   localparam int W  = 2 * N + 7;

   logic         clk;
   logic         rst;
   logic [3:0]   sw;
   logic         btn_enter;
   logic         btn_clear;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   ALUControl;
   logic         valid;
   logic [1:0]   stage;

   alu_operand_entry #(.n(N), .DEBOUNCE_CYCLES(DC)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw         (sw),
      .btn_enter  (btn_enter),
      .btn_clear  (btn_clear),
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .valid      (valid),
      .stage      (stage)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: raw button history, debounced level, pending press
   int           hist_e[$];
   int           hist_c[$];
   logic         m_lvl_e, m_lvl_c, m_ev_e, m_ev_c;
   int           m_st;
   logic [N-1:0] m_a, m_b;
   logic [3:0]   m_op;

   logic [W-1:0] exp_q[$];
   int           vectors;
   int           miscompares;

   // The debouncer sees the raw level from two edges back; a level flips once
   // the last DC such samples all disagree with it.
   function automatic logic [1:0] deb(input int h[$], input logic lvl);
      bit all_one, all_zero;
      all_one  = 1'b1;
      all_zero = 1'b1;
      for (int k = h.size() - 1 - DC; k <= h.size() - 2; k++) begin
         if (h[k] == 0) all_one = 1'b0;
         else           all_zero = 1'b0;
      end
      if (!lvl && all_one)  return 2'b11;
      if (lvl && all_zero)  return 2'b00;
      return {lvl, 1'b0};
   endfunction

   task automatic model_reset();
      hist_e.delete();
      hist_c.delete();
      for (int k = 0; k < DC + 2; k++) begin
         hist_e.push_back(0);
         hist_c.push_back(0);
      end
      m_lvl_e = 1'b0; m_lvl_c = 1'b0;
      m_ev_e  = 1'b0; m_ev_c  = 1'b0;
      m_st = 0; m_a = '0; m_b = '0; m_op = '0;
   endtask

   task automatic model_step(input logic e, input logic c, input logic [3:0] s, input logic r);
      logic [1:0] de, dc;
      if (r) begin
         model_reset();
      end else begin
         if (m_ev_c) begin
            m_st = 0; m_a = '0; m_b = '0; m_op = '0;
         end else if (m_ev_e) begin
            case (m_st)
               0:       begin m_a  = s[N-1:0]; m_st = 1; end
               1:       begin m_b  = s[N-1:0]; m_st = 2; end
               2:       begin m_op = s;        m_st = 3; end
               default: m_st = 0;
            endcase
         end
         de = deb(hist_e, m_lvl_e);
         dc = deb(hist_c, m_lvl_c);
         m_lvl_e = de[1]; m_ev_e = de[0];
         m_lvl_c = dc[1]; m_ev_c = dc[0];
         hist_e.push_back(int'(e));
         hist_c.push_back(int'(c));
         if (hist_e.size() > DC + 8) void'(hist_e.pop_front());
         if (hist_c.size() > DC + 8) void'(hist_c.pop_front());
      end
      exp_q.push_back({m_a, m_b, m_op, (m_st == 3), 2'(m_st)});
   endtask

   // driver tasks
   task automatic cyc(input logic e, input logic c, input logic [3:0] s, input logic r);
      @(negedge clk);
      btn_enter = e;
      btn_clear = c;
      sw        = s;
      rst       = r;
      model_step(e, c, s, r);
   endtask

   task automatic idle(input int k, input logic [3:0] s);
      repeat (k) cyc(1'b0, 1'b0, s, 1'b0);
   endtask

   task automatic press(input logic [3:0] s, input int hold, input int rel);
      repeat (hold) cyc(1'b1, 1'b0, s, 1'b0);
      idle(rel, s);
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // scoreboard monitor: one expected entry per clock edge
   initial begin
      logic [W-1:0] exp_v, act_v;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {a, b, ALUControl, valid, stage};
            vectors++;
            if (act_v !== exp_v) begin
               miscompares++;
               $display("FAIL edge_check t=%0t: got a=%0d b=%0d op=%0d v=%0b st=%0d, want %h (raw %h)",
                        $time, a, b, ALUControl, valid, stage, exp_v, act_v);
            end
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1; sw = '0; btn_enter = 1'b0; btn_clear = 1'b0;
      model_reset();

      repeat (2) cyc(1'b0, 1'b0, 4'd0, 1'b1);
      idle(20, 4'd0);
      chk("reset_idle", {a, b, ALUControl, valid, stage}, '0);

      press(4'd5, 10, 5);
      chk("load_a", {a, stage}, {3'd5, 2'd1});

      press(4'd3, 6, 8);
      press(4'd2, 6, 8);
      chk("show", {a, b, ALUControl, valid, stage}, {3'd5, 3'd3, 4'd2, 1'b1, 2'd3});
      press(4'd1, 6, 8);
      chk("wrap", {a, valid, stage}, {3'd5, 1'b0, 2'd0});

      cyc(1'b1, 1'b0, 4'd5, 1'b0); idle(5, 4'd5);
      repeat (2) cyc(1'b1, 1'b0, 4'd5, 1'b0); idle(5, 4'd5);
      repeat (3) cyc(1'b1, 1'b0, 4'd5, 1'b0); idle(5, 4'd5);
      chk("glitch_reject", {a, stage}, {3'd5, 2'd0});
      repeat (4) cyc(1'b1, 1'b0, 4'd5, 1'b0); idle(8, 4'd5);
      chk("glitch_4", {a, stage}, {3'd5, 2'd1});

      press(4'd3, 6, 8);
      chk("load_b", {a, b, stage}, {3'd5, 3'd3, 2'd2});
      repeat (6) cyc(1'b0, 1'b1, 4'd3, 1'b0); idle(8, 4'd3);
      chk("clear", {a, b, ALUControl, valid, stage}, '0);
      repeat (6) cyc(1'b1, 1'b1, 4'd6, 1'b0); idle(8, 4'd6);
      chk("clear_priority", {a, stage}, {3'd0, 2'd0});

      press(4'd1, 6, 8);
      press(4'd2, 6, 8);
      press(4'd7, 6, 8);
      chk("show2", {valid, stage}, {1'b1, 2'd3});
      cyc(1'b0, 1'b0, 4'd7, 1'b1);
      cyc(1'b0, 1'b0, 4'd7, 1'b0);
      chk("rst_in_show", {a, b, ALUControl, valid, stage}, '0);

      repeat (3) cyc(1'b1, 1'b0, 4'd4, 1'b0);
      cyc(1'b1, 1'b0, 4'd4, 1'b1);
      repeat (DC + 2) cyc(1'b1, 1'b0, 4'd4, 1'b0);
      chk("rst_mid_before", {a, stage}, {3'd0, 2'd0});
      repeat (4) cyc(1'b1, 1'b0, 4'd4, 1'b0);
      idle(8, 4'd4);
      chk("rst_mid_press", {a, stage}, {3'd4, 2'd1});

      for (int i = 0; i < 250; i++) begin
         logic e, c, r;
         logic [3:0] s;
         int len;
         e   = 1'($urandom_range(0, 1));
         c   = ($urandom_range(0, 5) == 0);
         r   = ($urandom_range(0, 39) == 0);
         s   = 4'($urandom_range(0, 15));
         len = $urandom_range(1, 8);
         cyc(e, c, s, r);
         repeat (len - 1) cyc(e, c, s, 1'b0);
      end
      idle(10, 4'd0);

      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
